// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if
// Handshake bundle between an operand-issue stage, the alu_pipe block and a
// result consumer.
//
//   in_valid  : operand beat valid (issuer -> ALU)
//   in_ready  : ALU can accept an operand beat (ALU -> issuer)
//   a, b      : operands, WIDTH bits
//   op        : 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   out_valid : result register holds an unconsumed result
//   out_ready : consumer accepts the result
//   result    : registered result, WIDTH bits
//   flag_z/n/c/v : zero / negative / carry-borrow-overflow-out / signed overflow
//   busy      : iterative multiply in progress
//
// Modports: master = issuer/consumer side, slave = the ALU.
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ADD,
// SUB, AND, OR, XOR, SHL, SHR and a WIDTH-cycle iterative unsigned multiply.
// Every result carries zero/negative/carry/overflow flags and is held in a
// one-entry output register until the consumer accepts it.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_pipe_if.slave (operand handshake, result handshake, busy)
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } alu_res_t;

    // Single-cycle operations. MUL is handled by the iterative datapath, so
    // its entry here only returns zeros.
    function automatic alu_res_t alu_comb(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op
    );
        alu_res_t                r;
        logic [WIDTH:0]          ext;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic signed [WIDTH-1:0] sr;
        r   = '0;
        ext = '0;
        sa  = signed'(a);
        sb  = signed'(b);
        sr  = '0;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                r.res = ext[WIDTH-1:0];
                r.c   = ext[WIDTH];
                sr    = signed'(r.res);
                r.v   = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
            end
            OP_SUB: begin
                ext   = {1'b0, a} - {1'b0, b};
                r.res = ext[WIDTH-1:0];
                // The extra bit of the extended difference is the borrow.
                r.c   = ext[WIDTH];
                sr    = signed'(r.res);
                r.v   = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
            end
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_XOR:  r.res = a ^ b;
            // Only the low SHW bits of b are a shift amount.
            OP_SHL:  r.res = a << b[SHW-1:0];
            OP_SHR:  r.res = a >> b[SHW-1:0];
            default: r     = '0;
        endcase
        return r;
    endfunction

    // One shift-add step: add the (pre-shifted) multiplicand when the
    // current multiplier LSB is set.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] acc,
        input logic [2*WIDTH-1:0] mcand,
        input logic               mbit
    );
        return mbit ? (acc + mcand) : acc;
    endfunction

    state_t             state_q,     state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q,    result_d;
    logic               z_q,         z_d;
    logic               n_q,         n_d;
    logic               c_q,         c_d;
    logic               v_q,         v_d;
    logic [SHW:0]       cnt_q,       cnt_d;
    logic [2*WIDTH-1:0] acc_q,       acc_d;
    logic [2*WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;

    logic               in_ready;
    logic               accept;
    alu_res_t           alu_r;
    logic [2*WIDTH-1:0] acc_step;

    // A new beat may enter only when idle and the output slot is empty or
    // being drained on this same edge.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        alu_r       = alu_comb(bus.a, bus.b, bus.op);
        acc_step    = mul_step(acc_q, mcand_q, mplier_q[0]);

        // A drain empties the slot unless a load below refills it.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = CNT_INIT;
                        state_d  = MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_r.res;
                        z_d         = ~|alu_r.res;
                        n_d         = alu_r.res[WIDTH-1];
                        c_d         = alu_r.c;
                        v_d         = alu_r.v;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_LAST;
                // Last step: the output slot is known empty here, so the
                // product goes straight into it.
                if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = acc_step[WIDTH-1:0];
                    z_d         = ~|acc_step[WIDTH-1:0];
                    n_d         = acc_step[WIDTH-1];
                    c_d         = |acc_step[2*WIDTH-1:WIDTH];
                    v_d         = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.busy      = (state_q == MUL);
endmodule
